// File: rtl/i2s_pkg.sv
// +--------------------------------------------------------------------+
// | i2s_pkg : shared sizes and sample-pair type for the I2S transmitter |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package i2s_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int BCLK_HALF  = 8;
    localparam int FRAME_BITS = 2 * SAMPLE_W;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } sample_pair_t;

endpackage

`default_nettype wire

// File: rtl/i2s_tx_if.sv
// +--------------------------------------------------------------------+
// | i2s_tx_if : stereo sample handshake between source and transmitter  |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface i2s_tx_if;
    import i2s_pkg::*;

    logic                valid;
    logic                ready;
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
    logic                underrun;

    modport master (output valid, left, right, input ready, underrun);
    modport slave  (input valid, left, right, output ready, underrun);

endinterface

`default_nettype wire

// File: rtl/i2s_clkgen.sv
// +--------------------------------------------------------------------+
// | i2s_clkgen : MCLK = clk/2, BCLK divider and registered fall strobe  |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module i2s_clkgen
    import i2s_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic mclk,
    output logic bclk,
    output logic fall_stb
);

    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    logic [DIV_W-1:0] div_cnt;

    // fall_stb is high in the same cycle BCLK is first seen low
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            bclk     <= 1'b0;
            mclk     <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            mclk     <= ~mclk;
            fall_stb <= 1'b0;
            if (div_cnt == DIV_W'(BCLK_HALF - 1)) begin
                div_cnt  <= '0;
                bclk     <= ~bclk;
                fall_stb <= bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2s_tx.sv
// +--------------------------------------------------------------------+
// | i2s_tx : I2S transmitter, one-entry holding register, MSB first     |
// | option I2S_TX_HOLD_LAST_EN: repeat last pair on underrun. rev 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module i2s_tx
    import i2s_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    i2s_tx_if.slave  bus,
    output logic     mclk,
    output logic     bclk,
    output logic     lrclk,
    output logic     sdin
);

    localparam int BC_W = $clog2(FRAME_BITS);

    logic                  fall_stb;
    logic [BC_W-1:0]       bit_cnt;
    logic [BC_W-1:0]       bit_nxt;
    logic [FRAME_BITS-1:0] sreg;
    sample_pair_t          hold;
    sample_pair_t          fallback;
    logic                  hold_valid;
    logic                  load_pt;
    logic                  xfer;

    i2s_clkgen u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .mclk     (mclk),
        .bclk     (bclk),
        .fall_stb (fall_stb)
    );

    // The fall into bit_cnt=1 places the left MSB one BCLK after LRCLK falls
    assign load_pt      = fall_stb && (bit_cnt == '0);
    assign bit_nxt      = (bit_cnt == BC_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
    assign xfer         = bus.valid && !hold_valid;
    assign bus.ready    = !hold_valid;
    assign bus.underrun = load_pt && !hold_valid;
    assign sdin         = sreg[FRAME_BITS-1];

`ifdef I2S_TX_HOLD_LAST_EN
    sample_pair_t last;

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= '0;
        end else if (load_pt && hold_valid) begin
            last <= hold;
        end
    end

    assign fallback = last;
`else
    assign fallback = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            lrclk      <= 1'b0;
            sreg       <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
        end else begin
            if (fall_stb) begin
                bit_cnt <= bit_nxt;
                lrclk   <= (bit_nxt >= BC_W'(SAMPLE_W));
                if (load_pt) begin
                    sreg       <= hold_valid ? hold : fallback;
                    hold_valid <= 1'b0;
                end else begin
                    sreg <= {sreg[FRAME_BITS-2:0], 1'b0};
                end
            end
            // Cannot coincide with a consuming load: ready is low then
            if (xfer) begin
                hold_valid <= 1'b1;
                hold       <= {bus.left, bus.right};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx.sv
// +--------------------------------------------------------------------+
// | tb_i2s_tx : directed + random stimulus against a frame-level model  |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_i2s_tx;
    import i2s_pkg::*;

    localparam int LOAD0     = 2 * BCLK_HALF;
    localparam int BIT_CYC   = 2 * BCLK_HALF;
    localparam int FRAME_CYC = FRAME_BITS * BIT_CYC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mclk, bclk, lrclk, sdin;

    i2s_tx_if bus ();

    i2s_tx dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .mclk  (mclk),
        .bclk  (bclk),
        .lrclk (lrclk),
        .sdin  (sdin)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int failures    = 0;
    int cyc         = 0;
    int frame_start = -1;
    int dut_xfers   = 0;
    int xfers_mark  = 0;
    bit model_accepted = 1'b0;
    bit pend_valid     = 1'b0;
    logic [FRAME_BITS-1:0] pend_word  = '0;
    logic [FRAME_BITS-1:0] last_word  = '0;
    logic [FRAME_BITS-1:0] frame_word = '0;
    logic [FRAME_BITS-1:0] sdata      = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mclk"}, 32'(mclk), 32'd0);
        chk({tag, "_bclk"}, 32'(bclk), 32'd0);
        chk({tag, "_lrclk"}, 32'(lrclk), 32'd0);
        chk({tag, "_sdin"}, 32'(sdin), 32'd0);
        chk({tag, "_underrun"}, 32'(bus.underrun), 32'd0);
        chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
    endtask

    task automatic model_reset();
        cyc         = 0;
        frame_start = -1;
        pend_valid  = 1'b0;
        pend_word   = '0;
        last_word   = '0;
        frame_word  = '0;
    endtask

    task automatic drive(input bit v, input logic [FRAME_BITS-1:0] w);
        bus.valid = v;
        {bus.left, bus.right} = w;
    endtask

    // Check this cycle's outputs against the frame schedule, update the model, advance.
    task automatic step();
        bit load, rise;
        int k;
        logic [FRAME_BITS-1:0] fallback;
`ifdef I2S_TX_HOLD_LAST_EN
        fallback = last_word;
`else
        fallback = '0;
`endif
        load = (cyc >= LOAD0) && (((cyc - LOAD0) % FRAME_CYC) == 0);
        rise = (cyc >= BCLK_HALF) && (((cyc - BCLK_HALF) % BIT_CYC) == 0);
        chk("mclk", 32'(mclk), 32'((cyc % 2) == 1));
        chk("bclk", 32'(bclk), 32'(((cyc / BCLK_HALF) % 2) == 1));
        chk("ready", 32'(bus.ready), 32'(!pend_valid));
        chk("underrun", 32'(bus.underrun), 32'(load && !pend_valid));
        if (rise) begin
            if (frame_start < 0) begin
                chk("sdin_idle", 32'(sdin), 32'd0);
                chk("lrclk_idle", 32'(lrclk), 32'd0);
            end else begin
                k = (cyc - frame_start + BCLK_HALF) / BIT_CYC;
                chk("sdin", 32'(sdin), 32'(frame_word[FRAME_BITS-k]));
                chk("lrclk", 32'(lrclk), 32'((k % FRAME_BITS) >= SAMPLE_W));
            end
        end
        if (bus.valid && bus.ready) dut_xfers++;
        model_accepted = bus.valid && !pend_valid;
        if (load) begin
            if (pend_valid) begin
                frame_word = pend_word;
                last_word  = pend_word;
                pend_valid = 1'b0;
            end else begin
                frame_word = fallback;
            end
            frame_start = cyc;
        end
        if (model_accepted) begin
            pend_valid = 1'b1;
            pend_word  = {bus.left, bus.right};
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until(input int stop);
        while (cyc < stop) step();
    endtask

    initial begin
        drive(1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        rst = 1'b0;
        model_reset();

        // Single known pair at cycle 0, then starvation for the following frame
        drive(1'b1, 32'hA5F0_0F5A);
        step();
        drive(1'b0, 32'($urandom));
        run_until(LOAD0 + 2 * FRAME_CYC);

        // Transfer on the exact underrun load cycle
        drive(1'b1, 32'($urandom));
        step();
        drive(1'b0, '0);
        run_until(LOAD0 + 3 * FRAME_CYC + 48);

        // Streaming with incrementing data
        sdata = 32'($urandom);
        drive(1'b1, sdata);
        run_until(LOAD0 + 4 * FRAME_CYC);
        xfers_mark = dut_xfers;
        while (cyc < LOAD0 + 8 * FRAME_CYC) begin
            step();
            if (model_accepted) begin
                sdata = sdata + 32'h0001_0001;
                drive(1'b1, sdata);
            end
        end
        chk("stream_xfers", 32'(dut_xfers - xfers_mark), 32'd4);
        while (cyc < LOAD0 + 8 * FRAME_CYC + 100) begin
            step();
            if (model_accepted) begin
                sdata = sdata + 32'h0001_0001;
                drive(1'b1, sdata);
            end
        end

        // Mid-frame reset with a pair held: it must never be transmitted
        chk("held_before_rst", 32'(bus.ready), 32'd0);
        rst = 1'b1;
        drive(1'b0, '0);
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst");
        rst = 1'b0;
        model_reset();
        run_until(LOAD0 + 2 * FRAME_CYC + BCLK_HALF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
